// File: rtl/spmv_pkg.sv
// Shared types for the SpMV row scheduler: default widths, the packed row
// descriptor and the fetch FSM state encoding.
package spmv_pkg;

  localparam int ROW_W_C  = 16;
  localparam int PTR_W_C  = 24;
  localparam int DESC_W_C = ROW_W_C + 2 * PTR_W_C;

  typedef struct packed {
    logic [ROW_W_C-1:0] row_id;
    logic [PTR_W_C-1:0] ptr_start;
    logic [PTR_W_C-1:0] nnz;
  } row_desc_t;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RD_FIRST   = 3'd1,
    S_WAIT_FIRST = 3'd2,
    S_RD         = 3'd3,
    S_WAIT       = 3'd4,
    S_PUSH       = 3'd5,
    S_DRAIN      = 3'd6,
    S_DONE       = 3'd7
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requesting lane at or above rr_ptr
// (with wrap) and returns the pointer value that follows the granted lane.
module rr_arbiter
  import spmv_pkg::*;
#(
  parameter  int NUM_PE = 4,
  localparam int IW     = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic [NUM_PE-1:0] req,
  input  logic              en,
  input  logic [IW-1:0]     rr_ptr,
  output logic [NUM_PE-1:0] gnt,
  output logic [IW-1:0]     rr_next
);

  int   lane_s;
  logic found_s;
  logic hit_s;

  // Priority search starting at rr_ptr; only the first hit is granted.
  always_comb begin
    gnt     = '0;
    rr_next = rr_ptr;
    found_s = 1'b0;
    hit_s   = 1'b0;
    lane_s  = 0;
    for (int i = 0; i < NUM_PE; i++) begin
      lane_s       = (int'(rr_ptr) + i) % NUM_PE;
      hit_s        = en && !found_s && req[lane_s];
      gnt[lane_s]  = gnt[lane_s] | hit_s;
      rr_next      = hit_s ? IW'((lane_s + 1) % NUM_PE) : rr_next;
      found_s      = found_s | hit_s;
    end
  end

endmodule

// File: rtl/row_sched.sv
// Row scheduler: walks CSR row_ptr, pushes one descriptor per row into the
// row FIFO and dispatches FIFO entries round-robin to the PE lanes.
module row_sched
  import spmv_pkg::*;
#(
  parameter int NUM_PE     = 4,
  parameter int ROW_W      = ROW_W_C,
  parameter int PTR_W      = PTR_W_C,
  parameter int FIFO_DEPTH = 16,
  parameter int DESC_W     = ROW_W + 2 * PTR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ROW_W-1:0]  num_rows,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ROW_W:0]    mem_addr,
  input  logic              mem_rd_valid,
  input  logic [PTR_W-1:0]  mem_rd_data,
  output logic              fifo_wr_en,
  output logic [DESC_W-1:0] fifo_din,
  output logic              fifo_rd_en,
  input  logic [DESC_W-1:0] fifo_dout,
  output logic [NUM_PE-1:0] pe_valid,
  input  logic [NUM_PE-1:0] pe_ready,
  output logic [DESC_W-1:0] pe_desc
);

  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam int IW    = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE = {{(OCC_W-1){1'b0}}, 1'b1};

  sched_state_t      state_r, state_nxt_s;
  logic [ROW_W-1:0]  num_rows_r, idx_r;
  logic [PTR_W-1:0]  prev_ptr_r, cur_ptr_r;
  logic [OCC_W-1:0]  occ_r, occ_nxt_s;
  logic [IW-1:0]     rr_ptr_r, rr_next_s;
  logic [NUM_PE-1:0] gnt_s;
  logic              occ_nz_s;
  logic [ROW_W:0]    idx_inc_s;
  logic              last_row_s;
  logic [DESC_W-1:0] desc_s;

  assign idx_inc_s  = {1'b0, idx_r} + {{ROW_W{1'b0}}, 1'b1};
  assign last_row_s = (idx_inc_s == {1'b0, num_rows_r});
  // nnz wraps modulo 2^PTR_W, matching the row_ptr arithmetic.
  assign desc_s     = {idx_r, prev_ptr_r, cur_ptr_r - prev_ptr_r};
  assign fifo_din   = fifo_wr_en ? desc_s : '0;
  assign occ_nz_s   = (occ_r != '0);

  // Fetch FSM next state and its Moore/credit-gated outputs.
  always_comb begin
    state_nxt_s = state_r;
    busy        = 1'b1;
    done        = 1'b0;
    mem_rd_en   = 1'b0;
    mem_addr    = '0;
    fifo_wr_en  = 1'b0;
    case (state_r)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt_s = (num_rows == '0) ? S_DONE : S_RD_FIRST;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RD_FIRST: begin
        mem_rd_en   = 1'b1;
        state_nxt_s = S_WAIT_FIRST;
      end
      S_WAIT_FIRST: begin
        if (mem_rd_valid) begin
          state_nxt_s = S_RD;
        end else begin
          state_nxt_s = S_WAIT_FIRST;
        end
      end
      S_RD: begin
        mem_rd_en   = 1'b1;
        mem_addr    = idx_inc_s;
        state_nxt_s = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rd_valid) begin
          state_nxt_s = S_PUSH;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_PUSH: begin
        if (occ_r < DEPTH_C) begin
          fifo_wr_en  = 1'b1;
          state_nxt_s = last_row_s ? S_DRAIN : S_RD;
        end else begin
          state_nxt_s = S_PUSH;
        end
      end
      S_DRAIN: begin
        if (occ_r == '0) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_DRAIN;
        end
      end
      S_DONE: begin
        busy        = 1'b0;
        done        = 1'b1;
        state_nxt_s = S_IDLE;
      end
      default: begin
        busy        = 1'b0;
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Credit count tracks FIFO occupancy from our own pushes and pops.
  always_comb begin
    case ({fifo_wr_en, fifo_rd_en})
      2'b10:   occ_nxt_s = occ_r + OCC_ONE;
      2'b01:   occ_nxt_s = occ_r - OCC_ONE;
      default: occ_nxt_s = occ_r;
    endcase
  end

  // State, row walk registers, credit count and arbitration pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      num_rows_r <= '0;
      idx_r      <= '0;
      prev_ptr_r <= '0;
      cur_ptr_r  <= '0;
      occ_r      <= '0;
      rr_ptr_r   <= '0;
    end else begin
      state_r  <= state_nxt_s;
      occ_r    <= occ_nxt_s;
      rr_ptr_r <= rr_next_s;
      if (state_r == S_IDLE && start) begin
        num_rows_r <= num_rows;
      end else begin
        num_rows_r <= num_rows_r;
      end
      if (state_r == S_WAIT_FIRST && mem_rd_valid) begin
        prev_ptr_r <= mem_rd_data;
        idx_r      <= '0;
      end else if (state_r == S_WAIT && mem_rd_valid) begin
        cur_ptr_r <= mem_rd_data;
      end else if (fifo_wr_en) begin
        prev_ptr_r <= cur_ptr_r;
        idx_r      <= idx_inc_s[ROW_W-1:0];
      end else begin
        prev_ptr_r <= prev_ptr_r;
      end
    end
  end

  rr_arbiter #(
    .NUM_PE (NUM_PE)
  ) u_arb (
    .req     (pe_ready),
    .en      (occ_nz_s),
    .rr_ptr  (rr_ptr_r),
    .gnt     (gnt_s),
    .rr_next (rr_next_s)
  );

  // A grant only goes to a ready lane, so the pop and transfer coincide.
  assign pe_valid   = gnt_s;
  assign fifo_rd_en = |gnt_s;
  assign pe_desc    = fifo_rd_en ? fifo_dout : '0;

endmodule

// File: tb/tb_row_sched.sv
// Directed bench for row_sched with a behavioural row FIFO and a variable
// latency row_ptr memory.
module tb_row_sched;
  import spmv_pkg::*;

  localparam int NUM_PE = 4, ROW_W = 16, PTR_W = 24, FIFO_DEPTH = 16;
  localparam int DESC_W = ROW_W + 2 * PTR_W;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [ROW_W-1:0]  num_rows = '0;
  logic busy, done, mem_rd_en, fifo_wr_en, fifo_rd_en;
  logic [ROW_W:0]    mem_addr;
  logic              mem_rd_valid = 1'b0;
  logic [PTR_W-1:0]  mem_rd_data = '0;
  logic [DESC_W-1:0] fifo_din, fifo_dout, pe_desc;
  logic [NUM_PE-1:0] pe_valid, pe_ready = '0;

  int vectors = 0, miscompares = 0;
  int push_cnt = 0, rd_cnt = 0, done_cnt = 0, valid_cnt = 0;
  int mem_lat = 1, pend_cnt = 0;
  logic [5:0] pend_addr = '0;
  logic [PTR_W-1:0]  rp [0:63];
  logic [DESC_W-1:0] fmem [0:15];
  logic [3:0] fw = '0, fr = '0;
  int disp_lane [$];
  logic [DESC_W-1:0] disp_desc [$];

  row_sched #(.NUM_PE(NUM_PE), .ROW_W(ROW_W), .PTR_W(PTR_W),
              .FIFO_DEPTH(FIFO_DEPTH), .DESC_W(DESC_W)) dut (
    .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .pe_valid(pe_valid), .pe_ready(pe_ready),
    .pe_desc(pe_desc)
  );

  always #5 clk = ~clk;

  // row_ptr memory: one response mem_lat cycles after each read request.
  always @(posedge clk) begin
    mem_rd_valid <= 1'b0;
    if (pend_cnt == 1) begin
      mem_rd_valid <= 1'b1;
      mem_rd_data  <= rp[pend_addr];
    end
    if (pend_cnt > 0) pend_cnt <= pend_cnt - 1;
    if (mem_rd_en) begin
      if (mem_lat <= 1) begin
        mem_rd_valid <= 1'b1;
        mem_rd_data  <= rp[mem_addr[5:0]];
      end else begin
        pend_cnt  <= mem_lat - 1;
        pend_addr <= mem_addr[5:0];
      end
    end
  end

  // Row FIFO with combinational head.
  always @(posedge clk) begin
    if (reset) begin
      fw <= '0;
      fr <= '0;
    end else begin
      if (fifo_wr_en) begin
        fmem[fw] <= fifo_din;
        fw <= fw + 4'd1;
      end
      if (fifo_rd_en) fr <= fr + 4'd1;
    end
  end
  assign fifo_dout = fmem[fr];

  // Event counters, dispatch log and per-dispatch handshake checks.
  always @(posedge clk) begin
    if (mem_rd_valid) valid_cnt++;
    if (!reset) begin
      if (fifo_wr_en) push_cnt++;
      if (mem_rd_en) rd_cnt++;
      if (done) done_cnt++;
      if (pe_valid != '0) begin
        int lane = -1;
        for (int i = 0; i < NUM_PE; i++) if (pe_valid[i]) lane = i;
        disp_lane.push_back(lane);
        disp_desc.push_back(pe_desc);
        vectors++;
        if ((pe_valid & ~pe_ready) != '0 || !$onehot(pe_valid) || fifo_rd_en !== 1'b1) begin
          miscompares++;
          $display("FAIL handshake: pe_valid=%b pe_ready=%b fifo_rd_en=%b, want one-hot subset of ready with pop",
                   pe_valid, pe_ready, fifo_rd_en);
        end
      end
    end
  end

  function automatic logic [DESC_W-1:0] mk(input int r, input int p, input int n);
    row_desc_t d;
    d.row_id    = ROW_W'(r);
    d.ptr_start = PTR_W'(p);
    d.nnz       = PTR_W'(n);
    return d;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; pe_ready = '0; mem_lat = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    disp_lane.delete(); disp_desc.delete();
    push_cnt = 0; rd_cnt = 0; done_cnt = 0;
  endtask

  task automatic start_matrix(input int n);
    @(negedge clk);
    num_rows = ROW_W'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cycles = i + 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, done, mem_rd_en, mem_addr, fifo_wr_en, fifo_rd_en, pe_valid} !== '0) begin
      miscompares++;
      $display("FAIL reset_ctl: got busy=%b done=%b rd=%b addr=%0d wr=%b pop=%b pe_valid=%b, want all 0",
               busy, done, mem_rd_en, mem_addr, fifo_wr_en, fifo_rd_en, pe_valid);
    end
    vectors++;
    if (fifo_din !== '0 || pe_desc !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got fifo_din=%h pe_desc=%h, want 0", fifo_din, pe_desc);
    end
    vectors++;
    if (dut.state_r !== S_IDLE || dut.occ_r !== '0 || dut.rr_ptr_r !== '0 || dut.idx_r !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got state=%0d occ=%0d rr=%0d idx=%0d, want 0",
               dut.state_r, dut.occ_r, dut.rr_ptr_r, dut.idx_r);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int cyc;
    apply_reset();
    rp[0] = 24'd0; rp[1] = 24'd2; rp[2] = 24'd2; rp[3] = 24'd5;
    pe_ready = 4'b0001;
    start_matrix(3);
    wait_done(200, cyc);
    // 3 rows at 3 cycles each, plus first fetch and drain: done on cycle 13.
    vectors++;
    if (cyc != 13) begin
      miscompares++;
      $display("FAIL basic_done_cycle: got %0d, want 13", cyc);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_busy_at_done: got %b, want 0", busy);
    end
    vectors++;
    if (disp_desc.size() != 3) begin
      miscompares++;
      $display("FAIL basic_count: got %0d, want 3", disp_desc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        logic [DESC_W-1:0] e;
        e = (i == 0) ? mk(0, 0, 2) : (i == 1) ? mk(1, 2, 0) : mk(2, 2, 3);
        vectors++;
        if (disp_desc[i] !== e || disp_lane[i] != 0) begin
          miscompares++;
          $display("FAIL basic_desc[%0d]: got %h lane %0d, want %h lane 0", i, disp_desc[i], disp_lane[i], e);
        end
      end
    end
    @(negedge clk);
    vectors++;
    if (dut.occ_r !== '0 || done_cnt != 1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_end: got occ=%0d done_pulses=%0d done=%b, want 0/1/0", dut.occ_r, done_cnt, done);
    end
  endtask

  task automatic test_empty();
    apply_reset();
    start_matrix(0);
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_done: got done=%b busy=%b, want 1/0", done, busy);
    end
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (rd_cnt != 0 || done_cnt != 1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_end: got reads=%0d pulses=%0d done=%b, want 0/1/0", rd_cnt, done_cnt, done);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    apply_reset();
    for (int i = 0; i <= 20; i++) rp[i] = PTR_W'(3 * i);
    start_matrix(20);
    repeat (150) @(negedge clk);
    vectors++;
    if (push_cnt != 16 || dut.state_r !== S_PUSH || dut.occ_r !== 5'd16 || fifo_wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_stall: got pushes=%0d state=%0d occ=%0d wr=%b, want 16/PUSH/16/0",
               push_cnt, dut.state_r, dut.occ_r, fifo_wr_en);
    end
    vectors++;
    if (disp_lane.size() != 0) begin
      miscompares++;
      $display("FAIL bp_no_dispatch: got %0d dispatches, want 0", disp_lane.size());
    end
    pe_ready = 4'b0100;
    wait_done(400, cyc);
    vectors++;
    if (cyc < 0 || disp_desc.size() != 20 || push_cnt != 20) begin
      miscompares++;
      $display("FAIL bp_total: got cyc=%0d dispatches=%0d pushes=%0d, want done/20/20", cyc, disp_desc.size(), push_cnt);
    end else begin
      for (int i = 0; i < 20; i++) begin
        vectors++;
        if (disp_desc[i] !== mk(i, 3 * i, 3) || disp_lane[i] != 2) begin
          miscompares++;
          $display("FAIL bp_desc[%0d]: got %h lane %0d, want %h lane 2", i, disp_desc[i], disp_lane[i], mk(i, 3 * i, 3));
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int cyc;
    apply_reset();
    rp[0] = 24'hFFFFFE; rp[1] = 24'd1;
    for (int i = 2; i <= 8; i++) rp[i] = PTR_W'(i);
    pe_ready = 4'b1111;
    start_matrix(8);
    wait_done(200, cyc);
    vectors++;
    if (cyc < 0 || disp_desc.size() != 8) begin
      miscompares++;
      $display("FAIL rr4_count: got cyc=%0d dispatches=%0d, want done/8", cyc, disp_desc.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        logic [DESC_W-1:0] e;
        e = (i == 0) ? mk(0, 24'hFFFFFE, 3) : mk(i, i, 1);
        vectors++;
        if (disp_desc[i] !== e || disp_lane[i] != i % 4) begin
          miscompares++;
          $display("FAIL rr4[%0d]: got %h lane %0d, want %h lane %0d", i, disp_desc[i], disp_lane[i], e, i % 4);
        end
      end
    end
    apply_reset();
    for (int i = 0; i <= 6; i++) rp[i] = PTR_W'(2 * i);
    pe_ready = 4'b1010;
    start_matrix(6);
    wait_done(200, cyc);
    vectors++;
    if (cyc < 0 || disp_desc.size() != 6) begin
      miscompares++;
      $display("FAIL rr2_count: got cyc=%0d dispatches=%0d, want done/6", cyc, disp_desc.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        vectors++;
        if (disp_desc[i] !== mk(i, 2 * i, 2) || disp_lane[i] != ((i % 2 == 0) ? 1 : 3)) begin
          miscompares++;
          $display("FAIL rr2[%0d]: got %h lane %0d, want %h lane %0d", i, disp_desc[i], disp_lane[i],
                   mk(i, 2 * i, 2), (i % 2 == 0) ? 1 : 3);
        end
      end
    end
  endtask

  task automatic test_simul_push_pop();
    int cyc;
    logic found;
    apply_reset();
    rp[0] = 24'd0; rp[1] = 24'd1; rp[2] = 24'd3; rp[3] = 24'd6;
    start_matrix(3);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (fifo_wr_en === 1'b1 && dut.occ_r === 5'd1) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL simul_setup: got no push with occ=1, want one");
    end else begin
      pe_ready = 4'b0001;
      #1;
      vectors++;
      if (fifo_rd_en !== 1'b1 || pe_valid !== 4'b0001 || pe_desc !== mk(0, 0, 1)) begin
        miscompares++;
        $display("FAIL simul_pop: got pop=%b pe_valid=%b desc=%h, want 1/0001/%h", fifo_rd_en, pe_valid, pe_desc, mk(0, 0, 1));
      end
      @(negedge clk);
      vectors++;
      if (dut.occ_r !== 5'd1) begin
        miscompares++;
        $display("FAIL simul_occ: got %0d, want 1", dut.occ_r);
      end
    end
    wait_done(200, cyc);
    vectors++;
    if (cyc < 0 || disp_desc.size() != 3 || disp_desc[0] !== mk(0, 0, 1) ||
        disp_desc[1] !== mk(1, 1, 2) || disp_desc[2] !== mk(2, 3, 3)) begin
      miscompares++;
      $display("FAIL simul_order: got cyc=%0d n=%0d, want 3 descs in row order", cyc, disp_desc.size());
    end
  endtask

  task automatic test_reset_mid();
    int cyc, v0, p0, d0;
    logic found;
    apply_reset();
    rp[0] = 24'd0; rp[1] = 24'd1; rp[2] = 24'd4;
    mem_lat = 4;
    pe_ready = 4'b0001;
    start_matrix(2);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (dut.state_r === S_WAIT) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL mid_reach_wait: got no WAIT state, want WAIT");
    end
    v0 = valid_cnt; p0 = push_cnt; d0 = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vectors++;
      if ({busy, done, mem_rd_en, fifo_wr_en, fifo_rd_en, pe_valid} !== '0 || dut.state_r !== S_IDLE) begin
        miscompares++;
        $display("FAIL mid_idle[%0d]: got busy=%b done=%b rd=%b wr=%b pop=%b state=%0d, want idle/0",
                 i, busy, done, mem_rd_en, fifo_wr_en, fifo_rd_en, dut.state_r);
      end
    end
    vectors++;
    if (valid_cnt != v0 + 1 || push_cnt != p0 || done_cnt != d0) begin
      miscompares++;
      $display("FAIL mid_late: got late_valids=%0d pushes=%0d dones=%0d, want 1/0/0",
               valid_cnt - v0, push_cnt - p0, done_cnt - d0);
    end
    mem_lat = 1;
    disp_lane.delete(); disp_desc.delete();
    start_matrix(2);
    wait_done(200, cyc);
    vectors++;
    if (cyc < 0 || disp_desc.size() != 2 || disp_desc[0] !== mk(0, 0, 1) ||
        disp_desc[1] !== mk(1, 1, 3) || disp_lane[0] != 0 || disp_lane[1] != 0) begin
      miscompares++;
      $display("FAIL mid_restart: got cyc=%0d n=%0d, want {0,0,1},{1,1,3} on lane 0", cyc, disp_desc.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_backpressure();
    test_round_robin();
    test_simul_push_pop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, want summary before time limit");
    $fatal(1, "watchdog");
  end

endmodule
